// File: rtl/seq_calc_if.sv
// Start/busy/done handshake and BCD operand/result bus for seq_calc_unit.
interface seq_calc_if #(
  parameter int DIGITS = 2
);
  logic                  start;
  logic [1:0]            op;
  logic [4*DIGITS-1:0]   a_bcd;
  logic [4*DIGITS-1:0]   b_bcd;
  logic                  busy;
  logic                  done;
  logic [8*DIGITS-1:0]   result_bcd;
  logic                  neg;
  logic                  err;

  modport master (
    output start, op, a_bcd, b_bcd,
    input  busy, done, result_bcd, neg, err
  );

  modport slave (
    input  start, op, a_bcd, b_bcd,
    output busy, done, result_bcd, neg, err
  );
endinterface

// File: rtl/seq_calc_unit.sv
// Multi-cycle BCD add/sub/mul/div core: BCD->bin, execute, double-dabble.
// Optional CALC_DIGIT_CHECK_EN flags operand nibbles above 9 as errors.
module seq_calc_unit #(
  parameter int DIGITS = 2
) (
  input  logic       clkin,
  input  logic       reset,
  seq_calc_if.slave  bus
);
  localparam int W  = 4*DIGITS;
  localparam int RW = 2*W;
  localparam int BW = 8*DIGITS;
  localparam int CW = $clog2(RW) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_EXEC, S_B2B, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic [W-1:0]    r_a_bcd;
  logic [W-1:0]    r_b_bcd;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_mq;
  logic [RW-1:0]   r_acc;
  logic [RW-1:0]   r_sh;
  logic [BW-1:0]   r_bcd;
  logic [BW-1:0]   r_result;
  logic            r_neg_p;
  logic            r_neg;
  logic            r_err;

  logic [3:0]      w_nib_a;
  logic [3:0]      w_nib_b;
  logic [W-1:0]    w_a_nxt;
  logic [W-1:0]    w_b_nxt;
  logic            w_last_conv;
  logic            w_last_exec;
  logic            w_last_b2b;
  logic            w_bad;
  logic            w_dz;
  logic [W:0]      w_shift;
  logic [W:0]      w_trial;
  logic [W:0]      w_rem;
  logic [W-1:0]    w_quo;
  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_bcd_nxt;

  assign w_nib_a = r_a_bcd[W-1 -: 4];
  assign w_nib_b = r_b_bcd[W-1 -: 4];
  assign w_a_nxt = (r_a * W'(10)) + W'(w_nib_a);
  assign w_b_nxt = (r_b * W'(10)) + W'(w_nib_b);

  assign w_last_conv = (r_cnt == CW'(DIGITS-1));
  assign w_last_exec = (r_cnt == CW'(W-1));
  assign w_last_b2b  = (r_cnt == CW'(RW-1));

`ifdef CALC_DIGIT_CHECK_EN
  logic r_bad;
  assign w_bad = r_bad | (w_nib_a > 4'd9)
               | (w_nib_b > 4'd9);
`else
  assign w_bad = 1'b0;
`endif

  assign w_dz = (r_op == 2'd3) && (w_b_nxt == '0);

  // Restoring divide: remainder lives in the low W+1 bits of r_sh
  assign w_shift = {r_sh[W-1:0], r_mq[W-1]};
  assign w_trial = w_shift - {1'b0, r_b};
  assign w_rem   = w_trial[W] ? w_shift : w_trial;
  assign w_quo   = {r_mq[W-2:0], ~w_trial[W]};

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 2*DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign w_bcd_nxt = (w_adj << 1) | BW'(r_acc[RW-1]);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.start) w_state_nxt = S_CONV;
      S_CONV:
        if (w_last_conv) begin
          if (w_bad || w_dz) w_state_nxt = S_DONE;
          else               w_state_nxt = S_EXEC;
        end
      S_EXEC:
        if (!r_op[1] || w_last_exec)
          w_state_nxt = S_B2B;
      S_B2B:
        if (w_last_b2b) w_state_nxt = S_DONE;
      S_DONE:
        w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_a_bcd  <= '0;
      r_b_bcd  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mq     <= '0;
      r_acc    <= '0;
      r_sh     <= '0;
      r_bcd    <= '0;
      r_result <= '0;
      r_neg_p  <= 1'b0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
`ifdef CALC_DIGIT_CHECK_EN
      r_bad    <= 1'b0;
`endif
    end else begin
      r_cnt <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_a_bcd <= bus.a_bcd;
            r_b_bcd <= bus.b_bcd;
            r_a     <= '0;
            r_b     <= '0;
`ifdef CALC_DIGIT_CHECK_EN
            r_bad   <= 1'b0;
`endif
          end
        end
        S_CONV: begin
          r_a     <= w_a_nxt;
          r_b     <= w_b_nxt;
          r_a_bcd <= r_a_bcd << 4;
          r_b_bcd <= r_b_bcd << 4;
          r_acc   <= '0;
          r_bcd   <= '0;
          r_neg_p <= 1'b0;
`ifdef CALC_DIGIT_CHECK_EN
          r_bad   <= w_bad;
`endif
          if (w_last_conv) begin
            if (r_op == 2'd2) begin
              r_sh <= RW'(w_a_nxt);
              r_mq <= w_b_nxt;
            end else begin
              r_sh <= '0;
              r_mq <= w_a_nxt;
            end
            if (w_bad || w_dz) begin
              r_result <= '0;
              r_neg    <= 1'b0;
              r_err    <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          unique case (r_op)
            2'd0: r_acc <= RW'(r_a) + RW'(r_b);
            2'd1: begin
              if (r_a >= r_b) begin
                r_acc <= RW'(r_a - r_b);
              end else begin
                r_acc   <= RW'(r_b - r_a);
                r_neg_p <= 1'b1;
              end
            end
            2'd2: begin
              if (r_mq[0]) r_acc <= r_acc + r_sh;
              r_sh <= r_sh << 1;
              r_mq <= r_mq >> 1;
            end
            default: begin
              r_sh <= RW'(w_rem);
              r_mq <= w_quo;
              if (w_last_exec) r_acc <= RW'(w_quo);
            end
          endcase
        end
        S_B2B: begin
          r_bcd <= w_bcd_nxt;
          r_acc <= r_acc << 1;
          if (w_last_b2b) begin
            r_result <= w_bcd_nxt;
            r_neg    <= r_neg_p;
            r_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.result_bcd = r_result;
  assign bus.neg        = r_neg;
  assign bus.err        = r_err;
endmodule
